ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the skid FIFO entries (power of two, >=2).
REQ-002 Parameter LEN_W, default 16, SHALL set the width of the beat-count input.
REQ-003 clk  input  1  SHALL be the single rising-edge clock.
REQ-004 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a transfer; ignored while busy=1.
REQ-006 base_addr  input  `ADDR_BUS_WIDTH  SHALL be the first word address, sampled when start is accepted.
REQ-007 len  input  LEN_W  SHALL be the number of words to read, sampled when start is accepted.
REQ-008 stride  input  `ADDR_BUS_WIDTH  SHALL be the address increment per word, present only with RD_STRIDE_EN.
REQ-009 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-010 done  output  1  SHALL be a one-cycle pulse at transfer completion.
REQ-011 ram  ram_intf.compute  SHALL drive cs, oe, addr, W_req, W_data and SHALL receive R_data.
REQ-012 out_valid  output  1  SHALL flag valid data on out_data.
REQ-013 out_ready  input  1  SHALL be the consumer acceptance; a beat transfers when out_valid & out_ready.
REQ-014 out_data  output  `DATA_BUS_WIDTH  SHALL be the FIFO head word.
REQ-015 out_last  output  1  SHALL be high with the final beat of a transfer only.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-017 IDLE: start with len!=0 SHALL latch base_addr/len, go to RUN; start with len==0 SHALL pulse done next cycle and stay in IDLE.
REQ-018 RUN: a read SHALL issue (cs=1, oe=1, addr=current) in any cycle where issued<len and fifo_count+inflight<FIFO_DEPTH; otherwise cs=oe=0.
REQ-019 Address SHALL advance by 1 per issued read (by stride with RD_STRIDE_EN), wrapping modulo 2^`ADDR_BUS_WIDTH.
REQ-020 RAM read latency SHALL be exactly 1 cycle: R_data sampled the cycle after issue is pushed into the FIFO.
REQ-021 RUN SHALL go to DRAIN in the cycle after the len-th read is issued.
REQ-022 DRAIN SHALL go to IDLE, and done SHALL pulse, in the cycle after the last beat is accepted by the consumer.
REQ-023 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-024 W_req SHALL be constant 0 and W_data constant 0.
REQ-025 FIFO SHALL never overflow; simultaneous push and pop at full or empty SHALL both take effect with count unchanged.
REQ-026 out_valid SHALL equal FIFO non-empty; out_data/out_last SHALL hold stable while out_valid & ~out_ready.
REQ-027 Beat order on the output SHALL equal address issue order; no beat dropped or duplicated.
REQ-028 len=1 SHALL produce one beat with out_last=1.

Reset
REQ-029 rstn low SHALL immediately force IDLE, busy=0, done=0, cs=0, oe=0, addr=0, out_valid=0, out_last=0, FIFO empty, counters 0.
REQ-030 Reset mid-transfer SHALL discard all in-flight and buffered data; no done pulse SHALL follow.

Configuration
REQ-031 Macro RD_STRIDE_EN defined SHALL add the stride port (latched with start) and apply it per issued read.
REQ-032 Macro RD_STRIDE_EN undefined SHALL omit the stride port and use a fixed increment of 1.

Verification
REQ-033 base=0x100, len=4, out_ready=1 -> addr 0x100..0x103 on consecutive cycles, four beats, out_last on 4th, done one cycle after 4th beat.
REQ-034 len=8, out_ready=0 for 10 cycles then 1 -> exactly 4 reads issued then cs=0, no data lost, 8 beats in order.
REQ-035 start with len=0 -> done pulse next cycle, busy stays 0, cs never asserted.
REQ-036 base=0xFFFFFFFE, len=3 (32-bit address) -> addr 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-037 rstn asserted after 2 of 6 beats -> all outputs at reset values that cycle, no done pulse, new start after reset runs normally.
REQ-038 RD_STRIDE_EN defined, base=0x40, stride=4, len=3 -> addr 0x40, 0x44, 0x48.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// ram_intf: single-port RAM bus between a compute-side master and the memory model.
// Bus widths come from ADDR_BUS_WIDTH / DATA_BUS_WIDTH (default 32 when not set by the build).
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

interface ram_intf;
    logic                       cs;
    logic                       oe;
    logic [`ADDR_BUS_WIDTH-1:0] addr;
    logic                       W_req;
    logic [`DATA_BUS_WIDTH-1:0] W_data;
    logic [`DATA_BUS_WIDTH-1:0] R_data;

    modport compute (output cs, oe, addr, W_req, W_data, input R_data);
    modport memory  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams len words from a 1-cycle-latency RAM through a skid FIFO.
// Optional macro RD_STRIDE_EN adds a stride port; otherwise the address steps by 1.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

// state | meaning
// IDLE  | waiting for start; len==0 start only pulses done
// RUN   | issuing reads while FIFO space (count + in-flight) allows
// DRAIN | all reads issued, waiting for the consumer to take the last beat
module ram_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [`ADDR_BUS_WIDTH-1:0] base_addr,
    input  logic [LEN_W-1:0]           len,
`ifdef RD_STRIDE_EN
    input  logic [`ADDR_BUS_WIDTH-1:0] stride,
`endif
    output logic                       busy,
    output logic                       done,
    ram_intf.compute                   ram,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`DATA_BUS_WIDTH-1:0] out_data,
    output logic                       out_last
);
    localparam int AW = `ADDR_BUS_WIDTH;
    localparam int DW = `DATA_BUS_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  step;
    logic [LEN_W-1:0] issue_left_q;
    logic           inflight_q;
    logic           inflight_last_q;
    logic           done_q;
    logic           issue;
    logic           last_issue;
    logic           push;
    logic           pop;

    logic [DW:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

`ifdef RD_STRIDE_EN
    logic [AW-1:0] stride_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stride_q <= '0;
        end else if (state_q == IDLE && start) begin
            stride_q <= stride;
        end
    end

    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    assign push       = inflight_q;
    assign pop        = out_valid & out_ready;
    assign last_issue = issue && (issue_left_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && len != '0) state_d = RUN;
            end
            RUN: begin
                // the read issued last cycle already owns a FIFO slot
                issue = (issue_left_q != '0) &&
                        ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && fifo_mem[rd_ptr_q][DW]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            done_q          <= (state_q == IDLE && start && len == '0) ||
                               (state_q == DRAIN && state_d == IDLE);
            if (state_q == IDLE && start) begin
                addr_q       <= base_addr;
                issue_left_q <= len;
            end else if (issue) begin
                addr_q       <= addr_q + step;
                issue_left_q <= issue_left_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {inflight_last_q, ram.R_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = fifo_mem[rd_ptr_q][DW-1:0];
    assign out_last   = out_valid & fifo_mem[rd_ptr_q][DW];

    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    assign ram.cs     = issue;
    assign ram.oe     = issue;
    assign ram.addr   = addr_q;
    assign ram.W_req  = 1'b0;
    assign ram.W_data = '0;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, address/beat scoreboard and directed scenarios.
// Build with RD_STRIDE_EN defined to include the stride scenario.
`timescale 1ns/1ps
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module tb_ram_stream_reader;
    localparam int AW    = `ADDR_BUS_WIDTH;
    localparam int DW    = `DATA_BUS_WIDTH;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [LEN_W-1:0] len = '0;
`ifdef RD_STRIDE_EN
    logic [AW-1:0]    stride = '0;
`endif
    logic             busy, done, out_valid, out_last;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;

    ram_intf ram ();

    ram_stream_reader #(.FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef RD_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .ram       (ram),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_done = 0;
    logic [AW-1:0] exp_addr_q [$];
    logic [DW:0]   exp_beat_q [$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a) ^ DW'(32'h5A5A_C3C3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ram.cs && ram.oe) ram.R_data <= mem_word(ram.addr);
    end

    logic        hold_chk = 1'b0;
    logic [DW:0] held = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            hold_chk <= 1'b0;
        end else begin
            if (hold_chk) chk("hold_stable", {out_last, out_data}, held);
            if (ram.cs) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("rd_addr", ram.addr, exp_addr_q.pop_front());
                chk("rd_oe", ram.oe, 1);
                chk("wr_idle", {ram.W_req, ram.W_data}, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_beat_q.size() == 0) chk("unexpected_beat", 1, 0);
                else chk("beat", {out_last, out_data}, exp_beat_q.pop_front());
            end
            if (done) n_done++;
            hold_chk <= out_valid && !out_ready;
            held     <= {out_last, out_data};
        end
    end

    task automatic start_xfer(input logic [AW-1:0] b, input logic [LEN_W-1:0] n,
                              input logic [AW-1:0] s);
        logic [AW-1:0] a;
        a = b;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        len = n;
`ifdef RD_STRIDE_EN
        stride = s;
`endif
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({(i == int'(n) - 1), mem_word(a)});
            a = a + s;
        end
        exp_done++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, (n != '0));
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int last_cyc;
        bit seen;
        last_cyc = -10;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_last) last_cyc = i;
            if (done) begin
                seen = 1'b1;
                chk("done_timing", i, last_cyc + 1);
                chk("busy_at_done", busy, 0);
                break;
            end
            if (rand_ready) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic settle();
        @(posedge clk); #1;
        chk("sb_empty", exp_addr_q.size() + exp_beat_q.size(), 0);
        chk("done_count", n_done, exp_done);
    endtask

    initial begin
        int cnt;
        #2 rstn = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs_oe", {ram.cs, ram.oe}, 0);
        chk("rst_addr", ram.addr, 0);
        chk("rst_valid_last", {out_valid, out_last}, 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;

        // basic burst, full-rate consumer
        out_ready = 1'b1;
        start_xfer(AW'(32'h100), 4, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cs_consecutive", ram.cs, 1);
        end
        wait_done(40, 0);
        settle();

        // consumer stalled: issue must stop once FIFO space is committed
        out_ready = 1'b0;
        start_xfer(AW'(32'h2000), 8, 1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram.cs) cnt++;
        end
        chk("reads_while_stalled", cnt, 4);
        chk("cs_low_when_full", ram.cs, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(60, 0);
        settle();

        // zero-length request
        start_xfer(AW'(32'h300), 0, 1);
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_cs", ram.cs, 0);
        @(negedge clk);
        chk("len0_done_single", done, 0);
        settle();

        // address wrap at top of space
        start_xfer(AW'(32'hFFFF_FFFE), 3, 1);
        wait_done(40, 0);
        settle();

        // single beat
        start_xfer(AW'(32'h777), 1, 1);
        wait_done(40, 0);
        settle();

        // random backpressure
        out_ready = 1'b0;
        start_xfer(AW'(32'h1000), 12, 1);
        wait_done(400, 1);
        out_ready = 1'b1;
        settle();

        // reset in the middle of a transfer
        start_xfer(AW'(32'h500), 6, 1);
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 2; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
        end
        chk("mid_beats_before_rst", cnt, 2);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy_done", {busy, done}, 0);
        chk("mid_rst_cs_oe", {ram.cs, ram.oe}, 0);
        chk("mid_rst_addr", ram.addr, 0);
        chk("mid_rst_valid_last", {out_valid, out_last}, 0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        exp_done--;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (6) @(negedge clk);
        settle();
        start_xfer(AW'(32'h200), 5, 1);
        wait_done(60, 0);
        settle();

`ifdef RD_STRIDE_EN
        start_xfer(AW'(32'h40), 3, AW'(4));
        wait_done(40, 0);
        settle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before 200us");
        $fatal(1, "watchdog");
    end
endmodule
